// File: rtl/amba_axi_pkg.sv
// amba_axi_pkg: AXI4 bus widths, burst/response encodings and the
// master-to-slave (s_axi_mosi_t) / slave-to-master (s_axi_miso_t) bundles.
package amba_axi_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 64;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_USER_WIDTH = 1;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10,
    AXI_BURST_RSVD  = 2'b11
  } axi_burst_t;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   awid;
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    axi_burst_t                awburst;
    logic                      awlock;
    logic [3:0]                awcache;
    logic [2:0]                awprot;
    logic [3:0]                awqos;
    logic [3:0]                awregion;
    logic [AXI_USER_WIDTH-1:0] awuser;
    logic                      awvalid;
    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic [AXI_STRB_WIDTH-1:0] wstrb;
    logic                      wlast;
    logic [AXI_USER_WIDTH-1:0] wuser;
    logic                      wvalid;
    logic                      bready;
    logic [AXI_ID_WIDTH-1:0]   arid;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    axi_burst_t                arburst;
    logic                      arlock;
    logic [3:0]                arcache;
    logic [2:0]                arprot;
    logic [3:0]                arqos;
    logic [3:0]                arregion;
    logic [AXI_USER_WIDTH-1:0] aruser;
    logic                      arvalid;
    logic                      rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                      awready;
    logic                      wready;
    logic [AXI_ID_WIDTH-1:0]   bid;
    axi_resp_t                 bresp;
    logic [AXI_USER_WIDTH-1:0] buser;
    logic                      bvalid;
    logic                      arready;
    logic [AXI_ID_WIDTH-1:0]   rid;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    axi_resp_t                 rresp;
    logic                      rlast;
    logic [AXI_USER_WIDTH-1:0] ruser;
    logic                      rvalid;
  } s_axi_miso_t;

endpackage

// File: rtl/dma_utils_pkg.sv
// dma_utils_pkg: channel FSM state encodings and burst address helpers
// shared by the write and read channels of dma_axi_sram.
package dma_utils_pkg;
  import amba_axi_pkg::*;

  // Largest legal beat size: one full data-bus word.
  localparam logic [2:0] AXI_MAX_SIZE = 3'($clog2(AXI_STRB_WIDTH));

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // WRAP and reserved encodings are not supported by this slave.
  function automatic logic burst_is_bad(input axi_burst_t burst);
    return (burst != AXI_BURST_FIXED) && (burst != AXI_BURST_INCR);
  endfunction

  // Address of the following beat. Oversized beats step by one bus word;
  // anything that is not FIXED steps like INCR.
  function automatic logic [AXI_ADDR_WIDTH-1:0] next_beat_addr(
    input logic [AXI_ADDR_WIDTH-1:0] addr,
    input logic [2:0]                size,
    input axi_burst_t                burst
  );
    logic [2:0] eff_size;
    eff_size = (size > AXI_MAX_SIZE) ? AXI_MAX_SIZE : size;
    if (burst == AXI_BURST_FIXED) return addr;
    return addr + (AXI_ADDR_WIDTH'(1) << eff_size);
  endfunction

endpackage

// File: rtl/dma_sram_array.sv
// dma_sram_array: single-clock storage, one byte-enabled write port and one
// registered read port. A read and a write to the same word in one cycle
// return the old contents (read-before-write).
//   clk          clock
//   we/waddr     write enable and word index
//   wdata/wstrb  write data and per-byte enables
//   re/raddr     read enable and word index; rdata updates only when re=1
//   rdata        registered read data
module dma_sram_array #(
  parameter int WORDS  = 1024,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem [WORDS];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (we && wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (re) rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;
endmodule

// File: rtl/dma_axi_sram.sv
// dma_axi_sram: AXI4 slave SRAM target for the DMA master port.
// Independent write (AW/W/B) and read (AR/R) FSMs share one storage array.
//   clk         single clock
//   rst         asynchronous, active-high reset
//   axi_mosi_i  AXI4 requests from the DMA master
//   axi_miso_o  AXI4 responses to the DMA master
// All ready/valid outputs are registered, so no valid input reaches a ready
// output combinationally.
module dma_axi_sram
  import amba_axi_pkg::*;
  import dma_utils_pkg::*;
#(
  parameter int                        MEM_WORDS = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  s_axi_mosi_t axi_mosi_i,
  output s_axi_miso_t axi_miso_o
);
  localparam int BYTE_SHIFT = $clog2(AXI_STRB_WIDTH);
  localparam int WORD_AW    = $clog2(MEM_WORDS);
  localparam logic [AXI_ADDR_WIDTH:0] MEM_BYTES = (AXI_ADDR_WIDTH+1)'(MEM_WORDS) << BYTE_SHIFT;

  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return (addr >= BASE_ADDR) && ({1'b0, addr - BASE_ADDR} < MEM_BYTES);
  endfunction

  function automatic logic [WORD_AW-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return WORD_AW'((addr - BASE_ADDR) >> BYTE_SHIFT);
  endfunction

  // ---------------- write channel ----------------
  wr_state_t                 wr_state_reg;
  logic                      awready_reg, wready_reg, bvalid_reg, wr_err_reg;
  logic [AXI_ID_WIDTH-1:0]   wr_id_reg, bid_reg;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr_reg;
  logic [7:0]                wr_len_reg, wr_beat_reg;
  logic [2:0]                wr_size_reg;
  axi_burst_t                wr_burst_reg;
  axi_resp_t                 bresp_reg;

  logic aw_hs, w_hs, wr_last_beat, wr_beat_err;
  assign aw_hs        = axi_mosi_i.awvalid && awready_reg;
  assign w_hs         = axi_mosi_i.wvalid && wready_reg;
  // Burst length comes from the beat counter; wlast is only cross-checked.
  assign wr_last_beat = (wr_beat_reg == wr_len_reg);
  assign wr_beat_err  = !in_range(wr_addr_reg) || (axi_mosi_i.wlast != wr_last_beat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_reg <= W_IDLE;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
      wr_err_reg   <= 1'b0;
      wr_id_reg    <= '0;
      bid_reg      <= '0;
      wr_addr_reg  <= '0;
      wr_len_reg   <= '0;
      wr_beat_reg  <= '0;
      wr_size_reg  <= '0;
      wr_burst_reg <= AXI_BURST_FIXED;
      bresp_reg    <= AXI_RESP_OKAY;
    end else begin
      case (wr_state_reg)
        W_IDLE: begin
          awready_reg <= 1'b1;
          if (aw_hs) begin
            wr_id_reg    <= axi_mosi_i.awid;
            wr_addr_reg  <= axi_mosi_i.awaddr;
            wr_len_reg   <= axi_mosi_i.awlen;
            wr_size_reg  <= axi_mosi_i.awsize;
            wr_burst_reg <= axi_mosi_i.awburst;
            wr_beat_reg  <= '0;
            wr_err_reg   <= burst_is_bad(axi_mosi_i.awburst) || (axi_mosi_i.awsize > AXI_MAX_SIZE);
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b1;
            wr_state_reg <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            wr_addr_reg <= next_beat_addr(wr_addr_reg, wr_size_reg, wr_burst_reg);
            wr_beat_reg <= wr_beat_reg + 8'd1;
            if (wr_last_beat) begin
              wready_reg   <= 1'b0;
              bvalid_reg   <= 1'b1;
              bid_reg      <= wr_id_reg;
              bresp_reg    <= (wr_err_reg || wr_beat_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
              wr_state_reg <= W_RESP;
            end else begin
              wr_err_reg <= wr_err_reg || wr_beat_err;
            end
          end
        end
        default: begin
          if (axi_mosi_i.bready) begin
            bvalid_reg   <= 1'b0;
            awready_reg  <= 1'b1;
            wr_err_reg   <= 1'b0;
            wr_state_reg <= W_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------- read channel ----------------
  rd_state_t                 rd_state_reg;
  logic                      arready_reg, rvalid_reg, rlast_reg, rd_bad_reg;
  logic [AXI_ID_WIDTH-1:0]   rid_reg;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr_reg, rd_next_addr;
  logic [7:0]                rd_len_reg, rd_beat_reg;
  logic [2:0]                rd_size_reg;
  axi_burst_t                rd_burst_reg;
  axi_resp_t                 rresp_reg;

  logic ar_hs, r_hs;
  assign ar_hs        = axi_mosi_i.arvalid && arready_reg;
  assign r_hs         = rvalid_reg && axi_mosi_i.rready;
  assign rd_next_addr = next_beat_addr(rd_addr_reg, rd_size_reg, rd_burst_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_reg <= R_IDLE;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rlast_reg    <= 1'b0;
      rd_bad_reg   <= 1'b0;
      rid_reg      <= '0;
      rd_addr_reg  <= '0;
      rd_len_reg   <= '0;
      rd_beat_reg  <= '0;
      rd_size_reg  <= '0;
      rd_burst_reg <= AXI_BURST_FIXED;
      rresp_reg    <= AXI_RESP_OKAY;
    end else begin
      case (rd_state_reg)
        R_IDLE: begin
          arready_reg <= 1'b1;
          if (ar_hs) begin
            rid_reg      <= axi_mosi_i.arid;
            rd_addr_reg  <= axi_mosi_i.araddr;
            rd_len_reg   <= axi_mosi_i.arlen;
            rd_size_reg  <= axi_mosi_i.arsize;
            rd_burst_reg <= axi_mosi_i.arburst;
            rd_bad_reg   <= burst_is_bad(axi_mosi_i.arburst);
            rd_beat_reg  <= '0;
            rlast_reg    <= (axi_mosi_i.arlen == 8'd0);
            rresp_reg    <= (!in_range(axi_mosi_i.araddr) || burst_is_bad(axi_mosi_i.arburst))
                            ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            arready_reg  <= 1'b0;
            rvalid_reg   <= 1'b1;
            rd_state_reg <= R_DATA;
          end
        end
        default: begin
          if (r_hs) begin
            if (rlast_reg) begin
              rvalid_reg   <= 1'b0;
              rlast_reg    <= 1'b0;
              arready_reg  <= 1'b1;
              rd_state_reg <= R_IDLE;
            end else begin
              rd_addr_reg <= rd_next_addr;
              rd_beat_reg <= rd_beat_reg + 8'd1;
              rlast_reg   <= (rd_beat_reg + 8'd1 == rd_len_reg);
              rresp_reg   <= (!in_range(rd_next_addr) || rd_bad_reg) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
          end
        end
      endcase
    end
  end

  // ---------------- storage ----------------
  // The RAM read register is only reloaded on AR or R handshakes, which keeps
  // rdata stable while the master stalls.
  logic                      ram_we, ram_re;
  logic [WORD_AW-1:0]        ram_waddr, ram_raddr;
  logic [AXI_DATA_WIDTH-1:0] ram_rdata;

  assign ram_we    = (wr_state_reg == W_DATA) && w_hs && in_range(wr_addr_reg);
  assign ram_waddr = word_idx(wr_addr_reg);
  assign ram_re    = ar_hs || (r_hs && !rlast_reg);
  assign ram_raddr = ar_hs ? word_idx(axi_mosi_i.araddr) : word_idx(rd_next_addr);

  dma_sram_array #(
    .WORDS (MEM_WORDS),
    .DATA_W(AXI_DATA_WIDTH),
    .ADDR_W(WORD_AW)
  ) u_sram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(axi_mosi_i.wdata),
    .wstrb(axi_mosi_i.wstrb),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // Sideband request fields carry no meaning for this target.
  logic unused_fields;
  assign unused_fields = ^{axi_mosi_i.awlock, axi_mosi_i.awcache, axi_mosi_i.awprot,
                           axi_mosi_i.awqos, axi_mosi_i.awregion, axi_mosi_i.awuser,
                           axi_mosi_i.wuser, axi_mosi_i.arlock, axi_mosi_i.arcache,
                           axi_mosi_i.arprot, axi_mosi_i.arqos, axi_mosi_i.arregion,
                           axi_mosi_i.aruser};

  always_comb begin
    axi_miso_o         = '0;
    axi_miso_o.awready = awready_reg;
    axi_miso_o.wready  = wready_reg;
    axi_miso_o.bid     = bid_reg;
    axi_miso_o.bresp   = bresp_reg;
    axi_miso_o.bvalid  = bvalid_reg;
    axi_miso_o.arready = arready_reg;
    axi_miso_o.rid     = rid_reg;
    // Errored beats and idle/reset cycles present zero data.
    axi_miso_o.rdata   = (rvalid_reg && rresp_reg == AXI_RESP_OKAY) ? ram_rdata : '0;
    axi_miso_o.rresp   = rresp_reg;
    axi_miso_o.rlast   = rlast_reg;
    axi_miso_o.rvalid  = rvalid_reg;
  end
endmodule

// File: tb/tb_dma_axi_sram.sv
module tb_dma_axi_sram;
  import amba_axi_pkg::*;

  localparam int MAX_WAIT = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;

  int checks = 0;
  int errors = 0;

  logic [63:0] wbuf [16];
  logic [7:0]  sbuf [16];
  logic [63:0] rdat [16];
  logic [1:0]  rrsp [16];
  logic        rlst [16];
  logic [3:0]  rids [16];
  int          rcount;

  logic [1:0]  wresp;
  logic [3:0]  wbid;
  logic        seen;

  dma_axi_sram #(.MEM_WORDS(1024), .BASE_ADDR(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .axi_mosi_i(mosi),
    .axi_miso_o(miso)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input axi_burst_t burst, input logic [3:0] id, input int bad_beat,
                           input bit rnd, output logic [1:0] resp, output logic [3:0] bid);
    int n;
    bit done;
    mosi.awaddr = addr; mosi.awlen = len; mosi.awsize = size;
    mosi.awburst = burst; mosi.awid = id; mosi.awvalid = 1'b1;
    n = 0;
    while (!miso.awready && n < MAX_WAIT) begin step(); n++; end
    check("aw_ready", miso.awready, 1);
    step();
    mosi.awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      mosi.wdata  = wbuf[b];
      mosi.wstrb  = sbuf[b];
      mosi.wlast  = (b == int'(len)) ^ (b == bad_beat);
      mosi.wvalid = 1'b1;
      n = 0;
      while (!miso.wready && n < MAX_WAIT) begin step(); n++; end
      check("w_ready", miso.wready, 1);
      step();
    end
    mosi.wvalid = 1'b0;
    mosi.wlast  = 1'b0;
    n = 0; done = 0; resp = 2'bxx; bid = 4'bxxxx;
    while (!done && n < MAX_WAIT) begin
      mosi.bready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (miso.bvalid && mosi.bready) begin
        resp = miso.bresp; bid = miso.bid; done = 1;
      end
      step(); n++;
    end
    mosi.bready = 1'b0;
    check("b_done", 64'(done), 1);
    $display("WRITE addr=%h len=%0d burst=%0d id=%0d -> bresp=%0d bid=%0d", addr, len, burst, id, resp, bid);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input axi_burst_t burst, input logic [3:0] id, input bit rnd);
    int n;
    bit stalled;
    logic [63:0] prev_data;
    logic [1:0]  prev_resp;
    mosi.araddr = addr; mosi.arlen = len; mosi.arsize = size;
    mosi.arburst = burst; mosi.arid = id; mosi.arvalid = 1'b1;
    n = 0;
    while (!miso.arready && n < MAX_WAIT) begin step(); n++; end
    check("ar_ready", miso.arready, 1);
    step();
    mosi.arvalid = 1'b0;
    check("r_latency", miso.rvalid, 1);
    rcount = 0; stalled = 0; n = 0; prev_data = '0; prev_resp = '0;
    while (rcount <= int'(len) && n < MAX_WAIT) begin
      mosi.rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (miso.rvalid) begin
        if (stalled) begin
          check("r_stable_data", miso.rdata, prev_data);
          check("r_stable_resp", miso.rresp, prev_resp);
        end
        if (mosi.rready) begin
          if (rcount < 16) begin
            rdat[rcount] = miso.rdata; rrsp[rcount] = miso.rresp;
            rlst[rcount] = miso.rlast; rids[rcount] = miso.rid;
          end
          rcount++;
          stalled = 0;
        end else begin
          stalled = 1; prev_data = miso.rdata; prev_resp = miso.rresp;
        end
      end
      step(); n++;
    end
    mosi.rready = 1'b0;
    check("r_beat_count", 64'(rcount), 64'(int'(len) + 1));
    check("r_idle_after", miso.rvalid, 0);
    $display("READ  addr=%h len=%0d burst=%0d id=%0d -> beats=%0d first=%h", addr, len, burst, id, rcount, rdat[0]);
  endtask

  initial begin
    mosi = '0;
    // reset state
    step(); step();
    check("rst_awready", miso.awready, 0);
    check("rst_wready", miso.wready, 0);
    check("rst_bvalid", miso.bvalid, 0);
    check("rst_arready", miso.arready, 0);
    check("rst_rvalid", miso.rvalid, 0);
    check("rst_resp_ids", {miso.bresp, miso.rresp, miso.bid, miso.rid}, 0);
    check("rst_rdata", miso.rdata, 0);
    rst = 1'b0;
    step();
    check("post_rst_awready", miso.awready, 1);
    check("post_rst_arready", miso.arready, 1);

    // wlast on the wrong beat -> SLVERR
    wbuf[0] = 64'h1; wbuf[1] = 64'h2; sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    axi_write(32'h200, 8'd1, 3'd3, AXI_BURST_INCR, 4'd7, 0, 0, wresp, wbid);
    check("bad_wlast_bresp", wresp, AXI_RESP_SLVERR);
    check("bad_wlast_bid", wbid, 4'd7);

    // 4-beat INCR write/read
    for (int i = 0; i < 4; i++) begin wbuf[i] = 64'(8'h11 * (i + 1)); sbuf[i] = 8'hFF; end
    axi_write(32'h0, 8'd3, 3'd3, AXI_BURST_INCR, 4'd3, -1, 0, wresp, wbid);
    check("incr_bresp", wresp, AXI_RESP_OKAY);
    check("incr_bid", wbid, 4'd3);
    axi_read(32'h0, 8'd3, 3'd3, AXI_BURST_INCR, 4'd5, 0);
    for (int i = 0; i < 4; i++) begin
      check("incr_rdata", rdat[i], 64'(8'h11 * (i + 1)));
      check("incr_rlast", rlst[i], (i == 3) ? 1 : 0);
      check("incr_rresp", rrsp[i], AXI_RESP_OKAY);
    end
    check("incr_rid", rids[0], 4'd5);

    // FIXED write A then B to word 8, FIXED read of 3 beats
    wbuf[0] = 64'hAAAA_AAAA_AAAA_AAAA; wbuf[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    axi_write(32'h40, 8'd1, 3'd3, AXI_BURST_FIXED, 4'd1, -1, 0, wresp, wbid);
    check("fixed_bresp", wresp, AXI_RESP_OKAY);
    axi_read(32'h40, 8'd2, 3'd3, AXI_BURST_FIXED, 4'd1, 0);
    for (int i = 0; i < 3; i++) check("fixed_rdata", rdat[i], 64'hBBBB_BBBB_BBBB_BBBB);
    check("fixed_rlast", {rlst[0], rlst[1], rlst[2]}, 3'b001);

    // out-of-range write and read
    wbuf[0] = 64'hDEAD_BEEF_DEAD_BEEF; sbuf[0] = 8'hFF;
    axi_write(32'h2000, 8'd0, 3'd3, AXI_BURST_INCR, 4'd2, -1, 0, wresp, wbid);
    check("oor_bresp", wresp, AXI_RESP_SLVERR);
    axi_read(32'h0, 8'd0, 3'd3, AXI_BURST_INCR, 4'd0, 0);
    check("oor_storage_unchanged", rdat[0], 64'h11);
    axi_read(32'h2000, 8'd0, 3'd3, AXI_BURST_INCR, 4'd0, 0);
    check("oor_rdata", rdat[0], 0);
    check("oor_rresp", rrsp[0], AXI_RESP_SLVERR);
    check("oor_rlast", rlst[0], 1);

    // partial strobe on a word preloaded with all ones
    wbuf[0] = '1; sbuf[0] = 8'hFF;
    axi_write(32'h8, 8'd0, 3'd3, AXI_BURST_INCR, 4'd0, -1, 0, wresp, wbid);
    wbuf[0] = 64'h0123_4567_89AB_CDEF; sbuf[0] = 8'h0F;
    axi_write(32'h8, 8'd0, 3'd3, AXI_BURST_INCR, 4'd0, -1, 0, wresp, wbid);
    check("strb_bresp", wresp, AXI_RESP_OKAY);
    axi_read(32'h8, 8'd0, 3'd3, AXI_BURST_INCR, 4'd0, 0);
    check("strb_rdata", rdat[0], 64'hFFFF_FFFF_89AB_CDEF);

    // WRAP read -> zero data, SLVERR
    axi_read(32'h0, 8'd1, 3'd3, AXI_BURST_WRAP, 4'd4, 0);
    check("wrap_rdata", {rdat[0], rdat[1]}, 128'h0);
    check("wrap_rresp", {rrsp[0], rrsp[1]}, {AXI_RESP_SLVERR, AXI_RESP_SLVERR});

    // oversized awsize -> SLVERR
    wbuf[0] = 64'h5; sbuf[0] = 8'hFF;
    axi_write(32'h300, 8'd0, 3'd4, AXI_BURST_INCR, 4'd9, -1, 0, wresp, wbid);
    check("oversize_bresp", wresp, AXI_RESP_SLVERR);

    // 16-beat bursts under random backpressure
    for (int i = 0; i < 16; i++) begin wbuf[i] = 64'h0BAD_0000_0000_0000 + 64'(i * 257); sbuf[i] = 8'hFF; end
    axi_write(32'h100, 8'd15, 3'd3, AXI_BURST_INCR, 4'd6, -1, 1, wresp, wbid);
    check("bp_bresp", wresp, AXI_RESP_OKAY);
    axi_read(32'h100, 8'd15, 3'd3, AXI_BURST_INCR, 4'd6, 1);
    for (int i = 0; i < 16; i++) begin
      check("bp_rdata", rdat[i], 64'h0BAD_0000_0000_0000 + 64'(i * 257));
      check("bp_rlast", rlst[i], (i == 15) ? 1 : 0);
    end

    // reset during beat 2 of an 8-beat read
    mosi.araddr = 32'h0; mosi.arlen = 8'd7; mosi.arsize = 3'd3;
    mosi.arburst = AXI_BURST_INCR; mosi.arid = 4'd2; mosi.arvalid = 1'b1;
    check("rstmid_arready", miso.arready, 1);
    step();
    mosi.arvalid = 1'b0;
    mosi.rready = 1'b1;
    check("rstmid_beat1", miso.rdata, 64'h11);
    step();
    check("rstmid_beat2_valid", miso.rvalid, 1);
    check("rstmid_beat2", miso.rdata, 64'hFFFF_FFFF_89AB_CDEF);
    rst = 1'b1;
    #1;
    check("rstmid_rvalid_drop", miso.rvalid, 0);
    check("rstmid_arready_low", miso.arready, 0);
    check("rstmid_rdata_zero", miso.rdata, 0);
    mosi.rready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    check("rstmid_arready_back", miso.arready, 1);
    mosi.rready = 1'b1;
    seen = 1'b0;
    repeat (8) begin seen = seen | miso.rvalid; step(); end
    mosi.rready = 1'b0;
    check("rstmid_no_stale", seen, 0);
    $display("RESET mid-read: stale beats seen=%0d", seen);
    axi_read(32'h0, 8'd0, 3'd3, AXI_BURST_INCR, 4'd0, 0);
    check("rstmid_storage_kept", rdat[0], 64'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
